regfile_mp: RTL and testbench

Parametrised multi-port register file for the MIPS datapath, the next-generation replacement for the single-write, dual-read file. It provides a configurable number of read and write ports, deterministic write-port priority, a hardwired-zero register 0 and a per-register pending-write scoreboard. The scoreboard lets the decode stage detect load-use and long-latency hazards. The block sits between decode (reads, claims) and writeback (writes).

---
 rtl/regfile_pkg.sv | 35 +++
 rtl/regfile_mp_scoreboard.sv | 70 +++++++
 rtl/regfile_mp.sv | 103 ++++++++++
 tb/tb_regfile_mp.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, limits and write-port priority helper for the multi-port register file.
// Optional forwarding is selected with the REGFILE_BYPASS_EN macro in the files that import this package.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_MAX = 4;
  localparam int NUM_WR_MAX = 2;
  localparam int ADDR_W_MAX = 8;   // widest index the priority helper accepts
  localparam int WR_IDX_W   = 1;
  localparam int ZERO_REG   = 0;

  typedef struct packed {
    logic                hit;
    logic [WR_IDX_W-1:0] port;
  } wr_win_t;

  // Scans ports in ascending order, so the highest-index enabled match wins.
  function automatic wr_win_t wr_winner(
    input logic [NUM_WR_MAX-1:0]            en,
    input logic [NUM_WR_MAX*ADDR_W_MAX-1:0] addrs,
    input logic [ADDR_W_MAX-1:0]            addr
  );
    wr_win_t r;
    r = '0;
    for (int w = 0; w < NUM_WR_MAX; w++) begin
      if (en[w] && (addrs[w*ADDR_W_MAX +: ADDR_W_MAX] == addr)) begin
        r.hit  = 1'b1;
        r.port = WR_IDX_W'(w);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by claims, cleared by committed writes.
// With REGFILE_BYPASS_EN, a same-cycle write hides the busy flag unless a same-cycle claim re-arms it.
module regfile_mp_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  // Clear before set: a claim and a write to one register in the same cycle leave it pending.
  always_comb begin
    pending_d = pending_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] != ZERO_IDX)) begin
        pending_d[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (claim_en && (claim_addr != ZERO_IDX)) begin
      pending_d[claim_addr] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic              hit;
    a       = '0;
    hit     = 1'b0;
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      a   = rd_addr[p*ADDR_W +: ADDR_W];
      hit = 1'b0;
      rd_busy[p] = pending_q[a] && (a != ZERO_IDX);
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == a)) begin
          hit = 1'b1;
        end
      end
      if (hit && !(claim_en && (claim_addr == a))) begin
        rd_busy[p] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired r0, highest-port-wins writes and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [NUM_WR_MAX-1:0]            en_pad;
  logic [NUM_WR_MAX*ADDR_W_MAX-1:0] addr_pad;

  // Widen the write ports to the fixed shape the priority helper expects.
  always_comb begin
    en_pad   = '0;
    addr_pad = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      en_pad[w] = wr_en[w];
      addr_pad[w*ADDR_W_MAX +: ADDR_W_MAX] = ADDR_W_MAX'(wr_addr[w*ADDR_W +: ADDR_W]);
    end
  end

  // r0 is never a write target, so it holds its reset value of zero forever.
  always_comb begin
    wr_win_t win;
    win   = '0;
    mem_d = mem_q;
    for (int i = ZERO_REG + 1; i < DEPTH; i++) begin
      win = wr_winner(en_pad, addr_pad, ADDR_W_MAX'(i));
      if (win.hit) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (int'(win.port) == w) begin
            mem_d[i] = wr_data[w*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    wr_win_t win;
    win     = '0;
    rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[p*DATA_W +: DATA_W] = mem_q[rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      win = wr_winner(en_pad, addr_pad, ADDR_W_MAX'(rd_addr[p*ADDR_W +: ADDR_W]));
      // Reset gates forwarding so the outputs read zero while reset is held.
      if (!reset && win.hit && (rd_addr[p*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (int'(win.port) == w) begin
            rd_data[p*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
          end
        end
      end
`endif
    end
  end

  regfile_mp_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .rd_busy    (rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with two read and two write ports; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             claim_en;
  logic [AW-1:0]    claim_addr;

  regfile_mp #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR),
    .NUM_WR (NW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  // Expected-response queue: kind 0 = rd_data, kind 1 = rd_busy
  typedef struct packed {
    logic [7:0]  tag;
    logic        kind;
    logic [0:0]  port;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  exp_t        e;
  logic [31:0] act;

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.kind == 1'b0) act = rd_data[int'(e.port)*DW +: DW];
      else                act = {31'd0, rd_busy[int'(e.port)]};
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s port%0d step%0d: got 0x%08h want 0x%08h",
                 (e.kind == 1'b0) ? "rd_data" : "rd_busy", e.port, e.tag, act, e.val);
      end
    end
  end

  // Driver tasks
  task automatic start();
    @(posedge clock);
    #1;
    wr_en    = '0;
    claim_en = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic claim(input logic [AW-1:0] a);
    claim_en   = 1'b1;
    claim_addr = a;
  endtask

  task automatic expect_rd(input logic [7:0] tag, input logic [0:0] p,
                           input logic [31:0] d, input logic b);
    exp_q.push_back('{tag: tag, kind: 1'b0, port: p, val: d});
    exp_q.push_back('{tag: tag, kind: 1'b1, port: p, val: {31'd0, b}});
  endtask

  initial begin
    reset      = 1'b1;
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    claim_en   = 1'b0;
    claim_addr = '0;
    rd_addr    = '0;

    // Reset held with random activity on every input
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      wr_en      = NW'($urandom_range(0, 3));
      wr_addr    = (NW*AW)'($urandom);
      wr_data    = {$urandom, $urandom};
      claim_en   = 1'($urandom_range(0, 1));
      claim_addr = AW'($urandom);
      rd_addr    = (NR*AW)'($urandom);
      expect_rd(8'd1, 1'b0, 32'h0, 1'b0);
      expect_rd(8'd1, 1'b1, 32'h0, 1'b0);
    end
    start();
    reset = 1'b0;
    set_rd(5'd0, 5'd0);

    // Basic write then read
    start(); wr(0, 5'd5, 32'hDEADBEEF); set_rd(5'd5, 5'd0);
    expect_rd(8'd2, 1'b0, BYP ? 32'hDEADBEEF : 32'h0, 1'b0);
    start();
    expect_rd(8'd3, 1'b0, 32'hDEADBEEF, 1'b0);

    // Register zero on every port, with a claim
    start(); wr(0, 5'd0, 32'h12345678); wr(1, 5'd0, 32'h12345678); claim(5'd0);
    set_rd(5'd0, 5'd0);
    expect_rd(8'd4, 1'b0, 32'h0, 1'b0);
    expect_rd(8'd4, 1'b1, 32'h0, 1'b0);
    start();
    expect_rd(8'd5, 1'b0, 32'h0, 1'b0);
    expect_rd(8'd5, 1'b1, 32'h0, 1'b0);

    // Collision: highest-index port wins
    start(); wr(0, 5'd7, 32'h1); wr(1, 5'd7, 32'h2); set_rd(5'd7, 5'd7);
    expect_rd(8'd6, 1'b0, BYP ? 32'h2 : 32'h0, 1'b0);
    expect_rd(8'd6, 1'b1, BYP ? 32'h2 : 32'h0, 1'b0);
    start();
    expect_rd(8'd7, 1'b0, 32'h2, 1'b0);
    expect_rd(8'd7, 1'b1, 32'h2, 1'b0);

    // Scoreboard claim / clear on r9
    start(); claim(5'd9); set_rd(5'd5, 5'd9);
    expect_rd(8'd8, 1'b1, 32'h0, 1'b0);
    start(); expect_rd(8'd9,  1'b1, 32'h0, 1'b1);
    start(); expect_rd(8'd10, 1'b1, 32'h0, 1'b1);
    start(); wr(0, 5'd9, 32'hA5);
    expect_rd(8'd11, 1'b1, BYP ? 32'hA5 : 32'h0, BYP ? 1'b0 : 1'b1);
    start(); expect_rd(8'd12, 1'b1, 32'hA5, 1'b0);

    // Claim and write together: claim wins
    start(); claim(5'd9); wr(1, 5'd9, 32'hB6);
    expect_rd(8'd13, 1'b1, BYP ? 32'hB6 : 32'hA5, 1'b0);
    start(); expect_rd(8'd14, 1'b1, 32'hB6, 1'b1);
    start(); claim(5'd9); wr(0, 5'd9, 32'hC7);
    expect_rd(8'd15, 1'b1, BYP ? 32'hC7 : 32'hB6, 1'b1);
    start(); expect_rd(8'd16, 1'b1, 32'hC7, 1'b1);

    // Forwarding on read port 1
    start(); set_rd(5'd5, 5'd3); wr(0, 5'd3, 32'hCAFE);
    expect_rd(8'd17, 1'b1, BYP ? 32'hCAFE : 32'h0, 1'b0);
    expect_rd(8'd17, 1'b0, 32'hDEADBEEF, 1'b0);
    start(); expect_rd(8'd18, 1'b1, 32'hCAFE, 1'b0);

    // Asynchronous reset between edges discards state and an in-flight write
    start(); claim(5'd4); wr(0, 5'd6, 32'h55); set_rd(5'd6, 5'd4);
    expect_rd(8'd19, 1'b0, BYP ? 32'h55 : 32'h0, 1'b0);
    expect_rd(8'd19, 1'b1, 32'h0, 1'b0);
    start();
    expect_rd(8'd20, 1'b0, 32'h55, 1'b0);
    expect_rd(8'd20, 1'b1, 32'h0, 1'b1);
    start(); wr(0, 5'd6, 32'h77);
    #2;
    reset = 1'b1;
    expect_rd(8'd21, 1'b0, 32'h0, 1'b0);
    expect_rd(8'd21, 1'b1, 32'h0, 1'b0);
    start();
    expect_rd(8'd22, 1'b0, 32'h0, 1'b0);
    expect_rd(8'd22, 1'b1, 32'h0, 1'b0);
    start(); reset = 1'b0;
    expect_rd(8'd23, 1'b0, 32'h0, 1'b0);
    expect_rd(8'd23, 1'b1, 32'h0, 1'b0);
    start(); set_rd(5'd5, 5'd9);
    expect_rd(8'd24, 1'b0, 32'h0, 1'b0);
    expect_rd(8'd24, 1'b1, 32'h0, 1'b0);

    start();
    start();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
